// File: rtl/trap_controller.sv
// Machine-mode trap/mret sequencer and CSR file for the single-cycle core.
// Build option MTIMER_EN replaces the timer_irq pin with an internal mtime/mtimecmp timer.
module trap_controller #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_out,
   input  logic        instr_valid,
   input  logic        illegal_instr,
   input  logic        is_mret,
   input  logic        ext_irq,
`ifndef MTIMER_EN
   input  logic        timer_irq,
`endif
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        epc_taken,
   output logic [31:0] epc,
   output logic        kill
);

   logic                   mstatus_mie_q, mstatus_mie_d;
   logic                   mstatus_mpie_q, mstatus_mpie_d;
   logic                   mie_meie_q, mie_meie_d;
   logic                   mie_mtie_q, mie_mtie_d;
   logic [31:0]            mtvec_q, mtvec_d;
   logic [31:0]            mepc_q, mepc_d;
   logic [31:0]            mcause_q, mcause_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   logic        meip, mtip;
   logic        trap, mret, csr_wr;
   logic [31:0] trap_cause;

`ifdef MTIMER_EN
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        mtip_q, mtip_d;
   assign mtip = mtip_q;
`else
   assign mtip = timer_irq;
`endif

   assign meip = sync_q[SYNC_STAGES-1];

   // Trap decision; held off during reset so reset always wins over a trap.
   always_comb begin
      trap       = 1'b0;
      trap_cause = '0;
      if (rst_n && instr_valid) begin
         if (illegal_instr) begin
            trap       = 1'b1;
            trap_cause = 32'd2;
         end else if (mstatus_mie_q && mie_meie_q && meip) begin
            trap       = 1'b1;
            trap_cause = 32'h8000_000B;
         end else if (mstatus_mie_q && mie_mtie_q && mtip) begin
            trap       = 1'b1;
            trap_cause = 32'h8000_0007;
         end
      end
      mret      = rst_n && instr_valid && is_mret && !trap;
      csr_wr    = csr_we && !trap;
      kill      = trap;
      epc_taken = trap || mret;
      epc       = mret ? mepc_q : mtvec_q;
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
         12'h304: csr_rdata = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
         12'h305: csr_rdata = mtvec_q;
         12'h341: csr_rdata = mepc_q;
         12'h342: csr_rdata = mcause_q;
         12'h344: csr_rdata = {20'd0, meip, 3'd0, mtip, 7'd0};
`ifdef MTIMER_EN
         12'h7C0: csr_rdata = mtime_q[31:0];
         12'h7C1: csr_rdata = mtime_q[63:32];
         12'h7C2: csr_rdata = mtimecmp_q[31:0];
         12'h7C3: csr_rdata = mtimecmp_q[63:32];
`endif
         default: csr_rdata = '0;
      endcase
   end

   // Software writes first; trap/mret hardware updates then take precedence.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_meie_d     = mie_meie_q;
      mie_mtie_d     = mie_mtie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      sync_d         = {sync_q[SYNC_STAGES-2:0], ext_irq};
`ifdef MTIMER_EN
      mtime_d        = mtime_q + 64'd1;
      mtimecmp_d     = mtimecmp_q;
      mtip_d         = (mtime_q >= mtimecmp_q);
`endif
      if (csr_wr) begin
         case (csr_addr)
            12'h300: begin
               mstatus_mie_d  = csr_wdata[3];
               mstatus_mpie_d = csr_wdata[7];
            end
            12'h304: begin
               mie_meie_d = csr_wdata[11];
               mie_mtie_d = csr_wdata[7];
            end
            12'h305: mtvec_d  = csr_wdata & ~32'h3;
            12'h341: mepc_d   = csr_wdata & ~32'h3;
            12'h342: mcause_d = csr_wdata;
`ifdef MTIMER_EN
            12'h7C0: mtime_d    = {mtime_q[63:32], csr_wdata};
            12'h7C1: mtime_d    = {csr_wdata, mtime_q[31:0]};
            12'h7C2: mtimecmp_d = {mtimecmp_q[63:32], csr_wdata};
            12'h7C3: mtimecmp_d = {csr_wdata, mtimecmp_q[31:0]};
`endif
            default: ;
         endcase
      end
      if (trap) begin
         mepc_d         = pc_out & ~32'h3;
         mcause_d       = trap_cause;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mtvec_q        <= RESET_MTVEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
         sync_q         <= '0;
`ifdef MTIMER_EN
         mtime_q        <= '0;
         mtimecmp_q     <= '1;
         mtip_q         <= 1'b0;
`endif
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_meie_q     <= mie_meie_d;
         mie_mtie_q     <= mie_mtie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         sync_q         <= sync_d;
`ifdef MTIMER_EN
         mtime_q        <= mtime_d;
         mtimecmp_q     <= mtimecmp_d;
         mtip_q         <= mtip_d;
`endif
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller (default build): reset, illegal trap, external and
// timer interrupts with priority/masking, mret, CSR masking and unmapped addresses.
module tb_trap_controller;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        illegal_instr;
   logic        is_mret;
   logic        ext_irq;
   logic        timer_irq;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        epc_taken;
   logic [31:0] epc;
   logic        kill;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   trap_controller #(
      .RESET_MTVEC (32'h0000_0100),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid),
      .illegal_instr (illegal_instr),
      .is_mret       (is_mret),
      .ext_irq       (ext_irq),
`ifndef MTIMER_EN
      .timer_irq     (timer_irq),
`endif
      .csr_we        (csr_we),
      .csr_addr      (csr_addr),
      .csr_wdata     (csr_wdata),
      .csr_rdata     (csr_rdata),
      .epc_taken     (epc_taken),
      .epc           (epc),
      .kill          (kill)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance to the next negedge and return the per-instruction inputs to idle.
   task automatic cyc();
      @(negedge clk);
      instr_valid   = 1'b0;
      illegal_instr = 1'b0;
      is_mret       = 1'b0;
      csr_we        = 1'b0;
      csr_addr      = '0;
      csr_wdata     = '0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc();
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
      csr_addr = a;
      #1;
      chk(tag, csr_rdata, e);
   endtask

   task automatic outs(input logic t, input logic k, input string tag);
      #1;
      chk({tag, "_taken"}, {31'd0, epc_taken}, {31'd0, t});
      chk({tag, "_kill"},  {31'd0, kill},      {31'd0, k});
   endtask

   initial begin
      rst_n = 1'b0; pc_out = '0; instr_valid = 1'b0; illegal_instr = 1'b0; is_mret = 1'b0;
      ext_irq = 1'b0; timer_irq = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;

      // Reset, including an illegal instruction that reset must override
      cyc();
      outs(1'b0, 1'b0, "rst0");
      cyc();
      instr_valid = 1'b1; illegal_instr = 1'b1; pc_out = 32'h40;
      outs(1'b0, 1'b0, "rst_trap");
      chk("rst_epc", epc, 32'h100);
      cyc();
      rst_n = 1'b1;
      rd(12'h305, 32'h100, "rst_mtvec");
      rd(12'h300, 32'h0,   "rst_mstatus");
      rd(12'h341, 32'h0,   "rst_mepc");
      rd(12'h342, 32'h0,   "rst_mcause");
      rd(12'h304, 32'h0,   "rst_mie");
      rd(12'h344, 32'h0,   "rst_mip");

      // Invalid instruction never traps
      cyc();
      illegal_instr = 1'b1;
      outs(1'b0, 1'b0, "noval");

      // Illegal at 0x40 with MIE=0; the same-cycle mtvec write is killed
      cyc();
      instr_valid = 1'b1; illegal_instr = 1'b1; pc_out = 32'h40;
      csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h200;
      outs(1'b1, 1'b1, "ill");
      chk("ill_epc", epc, 32'h100);
      cyc();
      rd(12'h341, 32'h40,  "ill_mepc");
      rd(12'h342, 32'd2,   "ill_mcause");
      rd(12'h305, 32'h100, "ill_mtvec_kept");

      // CSR write masking
      wr(12'h305, 32'h203);
      wr(12'h304, 32'hFFFF_FFFF);
      wr(12'h300, 32'hFFFF_FFFF);
      cyc();
      rd(12'h305, 32'h200, "mtvec_align");
      rd(12'h304, 32'h880, "mie_mask");
      rd(12'h300, 32'h88,  "mstatus_mask");

      // External interrupt: visible to the trap logic after two sync stages
      cyc();
      ext_irq = 1'b1; instr_valid = 1'b1; pc_out = 32'h78;
      outs(1'b0, 1'b0, "ext_c0");
      cyc();
      instr_valid = 1'b1; pc_out = 32'h7C;
      outs(1'b0, 1'b0, "ext_c1");
      cyc();
      instr_valid = 1'b1; pc_out = 32'h80;
      outs(1'b1, 1'b1, "ext_c2");
      chk("ext_epc", epc, 32'h200);
      cyc();
      ext_irq = 1'b0;
      rd(12'h344, 32'h800,        "ext_mip_level");
      rd(12'h341, 32'h80,         "ext_mepc");
      rd(12'h342, 32'h8000_000B,  "ext_mcause");
      rd(12'h300, 32'h80,         "ext_mstatus");
      cyc(); cyc(); cyc();
      rd(12'h344, 32'h0, "ext_mip_clr");

      // mret back to 0x84
      wr(12'h341, 32'h87);
      cyc();
      rd(12'h341, 32'h84, "mepc_align");
      instr_valid = 1'b1; is_mret = 1'b1; pc_out = 32'h90;
      outs(1'b1, 1'b0, "mret");
      chk("mret_epc", epc, 32'h84);
      cyc();
      rd(12'h300, 32'h88, "mret_mstatus");

      // Both pending and enabled: external wins; masked ext leaves timer
      cyc();
      ext_irq = 1'b1; timer_irq = 1'b1;
      outs(1'b0, 1'b0, "pend_noval");
      rd(12'h344, 32'h080, "pend_mip_tim");
      cyc();
      cyc();
      rd(12'h344, 32'h880, "pend_mip_both");
      instr_valid = 1'b1; pc_out = 32'hA0;
      outs(1'b1, 1'b1, "both");
      cyc();
      rd(12'h342, 32'h8000_000B, "both_mcause");
      rd(12'h341, 32'hA0,        "both_mepc");
      wr(12'h304, 32'h080);
      cyc();
      csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h08;
      instr_valid = 1'b1; pc_out = 32'hAC;
      outs(1'b0, 1'b0, "enable_cycle");
      cyc();
      instr_valid = 1'b1; pc_out = 32'hB0;
      outs(1'b1, 1'b1, "tim");
      cyc();
      ext_irq = 1'b0; timer_irq = 1'b0;
      rd(12'h342, 32'h8000_0007, "tim_mcause");
      rd(12'h341, 32'hB0,        "tim_mepc");
      rd(12'h300, 32'h80,        "tim_mstatus");

      // Illegal mret: trap outranks mret
      cyc();
      instr_valid = 1'b1; is_mret = 1'b1; illegal_instr = 1'b1; pc_out = 32'hC0;
      outs(1'b1, 1'b1, "ill_mret");
      chk("ill_mret_epc", epc, 32'h200);
      cyc();
      rd(12'h342, 32'd2,  "ill_mret_mcause");
      rd(12'h341, 32'hC0, "ill_mret_mepc");
      rd(12'h300, 32'h00, "ill_mret_mstatus");

      // Unmapped and read-only CSRs
      wr(12'h7C0, 32'h123);
      cyc();
      rd(12'h7C0, 32'h0, "unmapped");
      wr(12'h344, 32'hFFFF_FFFF);
      cyc();
      rd(12'h344, 32'h0, "mip_ro");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
